// File: rtl/rv_alu_decoder_pipe.sv
// rv_alu_decoder_pipe: registered RV32 OP (and optional OP-IMM) ALU decoder with valid/ready
// handshakes and saturating statistics. Define DECODER_OPIMM_EN to compile in OP-IMM decoding.
module rv_alu_decoder_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       alu_op,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [4:0]       rd,
  output logic             rd_en,
  output logic             wr_en,
  output logic             use_imm,
  output logic [XLEN-1:0]  imm,
  output logic             illegal,
  output logic [CNT_W-1:0] decoded_count,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OpcOp    = 7'b0110011;
  localparam logic [6:0] F7Zero   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;

  localparam int unsigned AluAdd  = 0;
  localparam int unsigned AluSub  = 1;
  localparam int unsigned AluAnd  = 2;
  localparam int unsigned AluOr   = 3;
  localparam int unsigned AluSll  = 4;
  localparam int unsigned AluSlt  = 5;
  localparam int unsigned AluSltu = 6;
  localparam int unsigned AluXor  = 7;
  localparam int unsigned AluSrl  = 8;
  localparam int unsigned AluSra  = 9;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign funct7 = instruction[31:25];

  logic       accept;
  logic [9:0] dec_op;
  logic       dec_illegal;
  logic [4:0] dec_rs1, dec_rs2, dec_rd;
  logic       dec_rd_en, dec_wr_en;

  logic             out_valid_q, out_valid_d;
  logic [9:0]       alu_op_q, alu_op_d;
  logic [4:0]       rs1_q, rs1_d;
  logic [4:0]       rs2_q, rs2_d;
  logic [4:0]       rd_q, rd_d;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] decoded_count_q, decoded_count_d;
  logic [CNT_W-1:0] illegal_count_q, illegal_count_d;

`ifdef DECODER_OPIMM_EN
  localparam logic [6:0] OpcOpImm = 7'b0010011;

  logic            dec_imm_sel;
  logic [XLEN-1:0] dec_imm_raw;
  logic            dec_use_imm;
  logic [XLEN-1:0] dec_imm;
  logic            use_imm_q, use_imm_d;
  logic [XLEN-1:0] imm_q, imm_d;
`endif

  // Instruction decode; any encoding that leaves dec_op empty is illegal.
  always_comb begin
    dec_op = '0;
`ifdef DECODER_OPIMM_EN
    dec_imm_sel = 1'b0;
    dec_imm_raw = '0;
`endif
    case (opcode)
      OpcOp: begin
        if (funct7 == F7Zero) begin
          unique case (funct3)
            3'b000: dec_op[AluAdd]  = 1'b1;
            3'b001: dec_op[AluSll]  = 1'b1;
            3'b010: dec_op[AluSlt]  = 1'b1;
            3'b011: dec_op[AluSltu] = 1'b1;
            3'b100: dec_op[AluXor]  = 1'b1;
            3'b101: dec_op[AluSrl]  = 1'b1;
            3'b110: dec_op[AluOr]   = 1'b1;
            3'b111: dec_op[AluAnd]  = 1'b1;
          endcase
        end else if (funct7 == F7Alt) begin
          if (funct3 == 3'b000) dec_op[AluSub] = 1'b1;
          else if (funct3 == 3'b101) dec_op[AluSra] = 1'b1;
        end
      end
`ifdef DECODER_OPIMM_EN
      OpcOpImm: begin
        dec_imm_sel = 1'b1;
        dec_imm_raw = XLEN'($signed(instruction[31:20]));
        unique case (funct3)
          3'b000: dec_op[AluAdd]  = 1'b1;
          3'b010: dec_op[AluSlt]  = 1'b1;
          3'b011: dec_op[AluSltu] = 1'b1;
          3'b100: dec_op[AluXor]  = 1'b1;
          3'b110: dec_op[AluOr]   = 1'b1;
          3'b111: dec_op[AluAnd]  = 1'b1;
          3'b001: begin
            dec_imm_raw = XLEN'(instruction[24:20]);
            if (funct7 == F7Zero) dec_op[AluSll] = 1'b1;
          end
          3'b101: begin
            dec_imm_raw = XLEN'(instruction[24:20]);
            if (funct7 == F7Zero) dec_op[AluSrl] = 1'b1;
            else if (funct7 == F7Alt) dec_op[AluSra] = 1'b1;
          end
        endcase
      end
`endif
      default: ;
    endcase

    dec_illegal = (dec_op == '0);
    dec_rs1     = dec_illegal ? 5'd0 : instruction[19:15];
    dec_rd      = dec_illegal ? 5'd0 : instruction[11:7];
    dec_rd_en   = !dec_illegal;
    dec_wr_en   = !dec_illegal && (dec_rd != 5'd0);
`ifdef DECODER_OPIMM_EN
    dec_use_imm = dec_imm_sel && !dec_illegal;
    dec_imm     = dec_use_imm ? dec_imm_raw : '0;
    dec_rs2     = (dec_illegal || dec_use_imm) ? 5'd0 : instruction[24:20];
`else
    dec_rs2     = dec_illegal ? 5'd0 : instruction[24:20];
`endif
  end

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    out_valid_d     = out_valid_q;
    alu_op_d        = alu_op_q;
    rs1_d           = rs1_q;
    rs2_d           = rs2_q;
    rd_d            = rd_q;
    rd_en_d         = rd_en_q;
    wr_en_d         = wr_en_q;
    illegal_d       = illegal_q;
    decoded_count_d = decoded_count_q;
    illegal_count_d = illegal_count_q;
`ifdef DECODER_OPIMM_EN
    use_imm_d       = use_imm_q;
    imm_d           = imm_q;
`endif
    if (accept) begin
      out_valid_d = 1'b1;
      alu_op_d    = dec_op;
      rs1_d       = dec_rs1;
      rs2_d       = dec_rs2;
      rd_d        = dec_rd;
      rd_en_d     = dec_rd_en;
      wr_en_d     = dec_wr_en;
      illegal_d   = dec_illegal;
`ifdef DECODER_OPIMM_EN
      use_imm_d   = dec_use_imm;
      imm_d       = dec_imm;
`endif
      // Counters stick at all-ones rather than wrapping.
      if (dec_illegal) begin
        if (illegal_count_q != '1) illegal_count_d = illegal_count_q + CNT_W'(1);
      end else begin
        if (decoded_count_q != '1) decoded_count_d = decoded_count_q + CNT_W'(1);
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid_q     <= 1'b0;
      alu_op_q        <= '0;
      rs1_q           <= '0;
      rs2_q           <= '0;
      rd_q            <= '0;
      rd_en_q         <= 1'b0;
      wr_en_q         <= 1'b0;
      illegal_q       <= 1'b0;
      decoded_count_q <= '0;
      illegal_count_q <= '0;
`ifdef DECODER_OPIMM_EN
      use_imm_q       <= 1'b0;
      imm_q           <= '0;
`endif
    end else begin
      out_valid_q     <= out_valid_d;
      alu_op_q        <= alu_op_d;
      rs1_q           <= rs1_d;
      rs2_q           <= rs2_d;
      rd_q            <= rd_d;
      rd_en_q         <= rd_en_d;
      wr_en_q         <= wr_en_d;
      illegal_q       <= illegal_d;
      decoded_count_q <= decoded_count_d;
      illegal_count_q <= illegal_count_d;
`ifdef DECODER_OPIMM_EN
      use_imm_q       <= use_imm_d;
      imm_q           <= imm_d;
`endif
    end
  end

  assign out_valid     = out_valid_q;
  assign alu_op        = alu_op_q;
  assign rs1           = rs1_q;
  assign rs2           = rs2_q;
  assign rd            = rd_q;
  assign rd_en         = rd_en_q;
  assign wr_en         = wr_en_q;
  assign illegal       = illegal_q;
  assign decoded_count = decoded_count_q;
  assign illegal_count = illegal_count_q;
`ifdef DECODER_OPIMM_EN
  assign use_imm       = use_imm_q;
  assign imm           = imm_q;
`else
  assign use_imm       = 1'b0;
  assign imm           = '0;
`endif

endmodule
